// File: rtl/gray_ptr_pkg.sv
// ============================================================================
// Module : gray_ptr_pkg
// Brief  : Shared constants and Gray/binary conversion helpers for gray_ptr_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gray_ptr_pkg;

    localparam int SIDE_WR   = 0;
    localparam int SIDE_RD   = 1;
    localparam int PTR_MAX_W = 32;

    // Callers zero-extend narrower pointers; leading zeros leave both codes unchanged.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        logic [PTR_MAX_W-1:0] g;
        g[PTR_MAX_W-1] = b[PTR_MAX_W-1];
        for (int i = 0; i < PTR_MAX_W-1; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        return g;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_ptr_ctrl_ptr_sync.sv
// ============================================================================
// Module : ptr_sync
// Brief  : STAGES-deep, WIDTH-bit flop chain for a Gray pointer crossing domains.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_ptr_ctrl.sv
// ============================================================================
// Module : gray_ptr_ctrl
// Brief  : Async-FIFO pointer controller (write or read side): binary/Gray
//          pointer, remote-pointer synchroniser, full/empty flag, level.
//          Optional almost flag enabled by defining GRAY_PTR_ALMOST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_ptr_ctrl
    import gray_ptr_pkg::*;
#(
    parameter int ADDRLEN     = 4,
    parameter int SIDE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic               inc_ack,
    input  logic [ADDRLEN:0]   remote_gray,
    output logic [ADDRLEN:0]   ptr_bin,
    output logic [ADDRLEN-1:0] addr,
    output logic [ADDRLEN:0]   ptr_gray,
    output logic               flag,
    output logic [ADDRLEN:0]   level
`ifdef GRAY_PTR_ALMOST_EN
    ,
    output logic               almost
`endif
);

    localparam logic c_is_rd = (SIDE == SIDE_RD);

    if (ADDRLEN < 2) begin : g_bad_addrlen
        $error("gray_ptr_ctrl: ADDRLEN must be at least 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("gray_ptr_ctrl: SYNC_STAGES must be 2..4");
    end
    if (AF_THRESH < 0 || AF_THRESH > 2**ADDRLEN) begin : g_bad_thresh
        $error("gray_ptr_ctrl: AF_THRESH out of range");
    end

    logic               w_acc;
    logic [ADDRLEN:0]   w_rsync;
    logic [ADDRLEN:0]   w_rbin;
    logic [ADDRLEN:0]   ptr_bin_q,  ptr_bin_d;
    logic [ADDRLEN:0]   ptr_gray_q, ptr_gray_d;
    logic               flag_q,     flag_d;
    logic [ADDRLEN:0]   level_q,    level_d;

    ptr_sync #(
        .WIDTH  (ADDRLEN+1),
        .STAGES (SYNC_STAGES)
    ) u_ptr_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (remote_gray),
        .dout (w_rsync)
    );

    assign w_rbin = (ADDRLEN+1)'(gray2bin(PTR_MAX_W'(w_rsync)));

    // Flag and level are computed from next-state pointers so a local accept
    // is reflected on the same edge that moves the pointer.
    always_comb begin
        w_acc      = inc & ~flag_q;
        ptr_bin_d  = ptr_bin_q + {{ADDRLEN{1'b0}}, w_acc};
        ptr_gray_d = (ADDRLEN+1)'(bin2gray(PTR_MAX_W'(ptr_bin_d)));
        level_d    = ptr_bin_d - w_rbin;
        flag_d     = (ptr_gray_d == {~w_rsync[ADDRLEN:ADDRLEN-1], w_rsync[ADDRLEN-2:0]});
        if (c_is_rd) begin
            level_d = w_rbin - ptr_bin_d;
            flag_d  = (ptr_gray_d == w_rsync);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            flag_q     <= c_is_rd;
            level_q    <= '0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            flag_q     <= flag_d;
            level_q    <= level_d;
        end
    end

    assign inc_ack  = w_acc;
    assign ptr_bin  = ptr_bin_q;
    assign addr     = ptr_bin_q[ADDRLEN-1:0];
    assign ptr_gray = ptr_gray_q;
    assign flag     = flag_q;
    assign level    = level_q;

`ifdef GRAY_PTR_ALMOST_EN
    localparam logic [ADDRLEN:0] c_af_hi = (ADDRLEN+1)'(2**ADDRLEN - AF_THRESH);
    localparam logic [ADDRLEN:0] c_af_lo = (ADDRLEN+1)'(AF_THRESH);

    logic almost_q, almost_d;

    always_comb begin
        almost_d = (level_d >= c_af_hi);
        if (c_is_rd) begin
            almost_d = (level_d <= c_af_lo);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_q <= c_is_rd;
        end else begin
            almost_q <= almost_d;
        end
    end

    assign almost = almost_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_ptr_ctrl.sv
// ============================================================================
// Module : tb_gray_ptr_ctrl
// Brief  : Scoreboard bench driving a write-side and a read-side instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_ptr_ctrl;

    localparam int AW = 4;
    localparam int AF = 2;

    typedef struct {
        logic [4:0] ptr;
        logic [4:0] gray;
        logic [4:0] lvl;
        logic       flag;
        logic       alm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_inc = 1'b0, r_inc = 1'b0;
    logic [4:0] w_rem = '0, r_rem = '0;
    logic       w_ack, r_ack, w_flag, r_flag;
    logic [4:0] w_ptr, r_ptr, w_gray, r_gray, w_lvl, r_lvl;
    logic [3:0] w_addr, r_addr;
    logic       w_alm, r_alm;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb_w[$];
    exp_t sb_r[$];

    logic [4:0] m_ptr [2];
    logic [4:0] m_s0  [2];
    logic [4:0] m_s1  [2];
    logic       m_flag[2];
    logic       m_alm [2];

    always #5 clk = ~clk;

    gray_ptr_ctrl #(.ADDRLEN(AW), .SIDE(0), .SYNC_STAGES(2), .AF_THRESH(AF)) u_wr (
        .clk(clk), .rst(rst), .inc(w_inc), .inc_ack(w_ack), .remote_gray(w_rem),
        .ptr_bin(w_ptr), .addr(w_addr), .ptr_gray(w_gray), .flag(w_flag), .level(w_lvl)
`ifdef GRAY_PTR_ALMOST_EN
        , .almost(w_alm)
`endif
    );

    gray_ptr_ctrl #(.ADDRLEN(AW), .SIDE(1), .SYNC_STAGES(2), .AF_THRESH(AF)) u_rd (
        .clk(clk), .rst(rst), .inc(r_inc), .inc_ack(r_ack), .remote_gray(r_rem),
        .ptr_bin(r_ptr), .addr(r_addr), .ptr_gray(r_gray), .flag(r_flag), .level(r_lvl)
`ifdef GRAY_PTR_ALMOST_EN
        , .almost(r_alm)
`endif
    );

`ifndef GRAY_PTR_ALMOST_EN
    assign w_alm = 1'b0;
    assign r_alm = 1'b1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Occupancy-based reference: full when 16 entries apart, empty when equal.
    task automatic model_step(input int s, input logic r, input logic inc, input logic [4:0] rem);
        exp_t       e;
        logic [4:0] nb, rb, lv;
        if (r) begin
            m_ptr[s] = '0; m_s0[s] = '0; m_s1[s] = '0;
            m_flag[s] = (s == 1); m_alm[s] = (s == 1);
            lv = '0;
        end else begin
            nb = m_ptr[s] + {4'd0, inc & ~m_flag[s]};
            rb = g2b(m_s1[s]);
            lv = (s == 1) ? rb - nb : nb - rb;
            m_flag[s] = (s == 1) ? (lv == 5'd0) : (lv == 5'd16);
            m_alm[s]  = (s == 1) ? (int'(lv) <= AF) : (int'(lv) >= 16 - AF);
            m_ptr[s]  = nb;
            m_s1[s]   = m_s0[s];
            m_s0[s]   = rem;
        end
        e.ptr = m_ptr[s]; e.gray = b2g(m_ptr[s]); e.lvl = lv; e.flag = m_flag[s]; e.alm = m_alm[s];
        if (s == 0) sb_w.push_back(e); else sb_r.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_w.size() == 0 || sb_r.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_w.pop_front();
        check_eq("w_ptr",  32'(w_ptr),  32'(e.ptr));
        check_eq("w_addr", 32'(w_addr), 32'(e.ptr[3:0]));
        check_eq("w_gray", 32'(w_gray), 32'(e.gray));
        check_eq("w_flag", 32'(w_flag), 32'(e.flag));
        check_eq("w_lvl",  32'(w_lvl),  32'(e.lvl));
`ifdef GRAY_PTR_ALMOST_EN
        check_eq("w_alm",  32'(w_alm),  32'(e.alm));
`endif
        e = sb_r.pop_front();
        check_eq("r_ptr",  32'(r_ptr),  32'(e.ptr));
        check_eq("r_gray", 32'(r_gray), 32'(e.gray));
        check_eq("r_flag", 32'(r_flag), 32'(e.flag));
        check_eq("r_lvl",  32'(r_lvl),  32'(e.lvl));
`ifdef GRAY_PTR_ALMOST_EN
        check_eq("r_alm",  32'(r_alm),  32'(e.alm));
`endif
    endtask

    task automatic step(input logic r, input logic wi, input logic [4:0] wr,
                        input logic ri, input logic [4:0] rr);
        @(negedge clk);
        rst = r; w_inc = wi; w_rem = wr; r_inc = ri; r_rem = rr;
        #1;
        if (!r) begin
            check_eq("w_inc_ack", 32'(w_ack), 32'(wi & ~m_flag[0]));
            check_eq("r_inc_ack", 32'(r_ack), 32'(ri & ~m_flag[1]));
        end
        model_step(0, r, wi, wr);
        model_step(1, r, ri, rr);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] prev;

        // Reset
        step(1, 0, 0, 0, 0);
        check_eq("rst_w_flag", 32'(w_flag), 32'd0);
        check_eq("rst_r_flag", 32'(r_flag), 32'd1);
        check_eq("rst_w_ptr",  32'(w_ptr),  32'd0);
        check_eq("rst_w_lvl",  32'(w_lvl),  32'd0);

        // Fill write side against a stationary reader
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
        check_eq("fill_ptr",  32'(w_ptr),  32'b10000);
        check_eq("fill_gray", 32'(w_gray), 32'b11000);
        check_eq("fill_flag", 32'(w_flag), 32'd1);
        check_eq("fill_lvl",  32'(w_lvl),  32'd16);
        step(0, 1, 0, 0, 0);
        check_eq("full_ack",  32'(w_ack),  32'd0);
        check_eq("full_hold", 32'(w_ptr),  32'b10000);

        // Remote advance reaches the flag three edges later
        step(0, 0, 5'b00001, 0, 0);
        check_eq("lat_t1", 32'(w_flag), 32'd1);
        step(0, 0, 5'b00001, 0, 0);
        check_eq("lat_t2", 32'(w_flag), 32'd1);
        step(0, 0, 5'b00001, 0, 0);
        check_eq("lat_t3", 32'(w_flag), 32'd0);
        check_eq("lat_lvl", 32'(w_lvl), 32'd15);

        // Full Gray walk with the remote trailing the local pointer
        step(1, 0, 0, 0, 0);
        prev = w_gray;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check_eq("walk_pre_wrap", 32'(w_gray), 32'b10000);
            step(0, 1, b2g(m_ptr[0]), 0, 0);
            check_eq("walk_hamming", 32'($countones(w_gray ^ prev)), 32'd1);
            prev = w_gray;
        end
        check_eq("walk_wrap_gray", 32'(w_gray), 32'd0);
        check_eq("walk_wrap_ptr",  32'(w_ptr),  32'd0);

        // Read side against a writer holding five entries
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'b00111);
        check_eq("rd_flag", 32'(r_flag), 32'd0);
        check_eq("rd_lvl",  32'(r_lvl),  32'd5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 5'b00111);
        check_eq("rd_empty", 32'(r_flag), 32'd1);
        check_eq("rd_lvl0",  32'(r_lvl),  32'd0);
        check_eq("rd_ptr",   32'(r_ptr),  32'd5);
        step(0, 0, 0, 1, 5'b00111);
        check_eq("rd_hold",  32'(r_ptr),  32'd5);

        // Reset mid-run
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
        check_eq("mid_ptr9",  32'(w_ptr),  32'd9);
        check_eq("mid_flag",  32'(w_flag), 32'd0);
        step(1, 1, 0, 0, 0);
        check_eq("mid_rst_ptr", 32'(w_ptr), 32'd0);
        check_eq("mid_rst_lvl", 32'(w_lvl), 32'd0);

        // Almost-full threshold region
        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0);
        check_eq("af_lvl13", 32'(w_lvl), 32'd13);
`ifdef GRAY_PTR_ALMOST_EN
        check_eq("af_13", 32'(w_alm), 32'd0);
`endif
        step(0, 1, 0, 0, 0);
        check_eq("af_lvl14", 32'(w_lvl), 32'd14);
`ifdef GRAY_PTR_ALMOST_EN
        check_eq("af_14", 32'(w_alm), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
